// File: rtl/dbu_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dbu_run_ctrl_pkg
//  Purpose  : Shared debug-unit types and constants. Holds the run-control
//             state encoding and the default button debounce length.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dbu_run_ctrl_pkg;

   // Run-control states. The encoding is fixed so that debug tooling can
   // decode the state register directly.
   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } run_state_e;

   // Default debounce length: 1 ms at 50 MHz.
   localparam int c_DB_CYCLES_DEFAULT = 50000;

endpackage : dbu_run_ctrl_pkg
`default_nettype wire

// File: rtl/dbu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dbu_run_ctrl_if
//  Purpose  : Board/CPU-facing signal bundle of the run-control sequencer.
//  Ports    : master modport = board I/O + CPU side (drives switches, buttons,
//             breakpoint setup and PC; observes enable, address and status)
//             slave modport  = dbu_run_ctrl
//  Revision : 1.0  initial release
// ============================================================================
interface dbu_run_ctrl_if #(
   parameter int AW = 9
);
   logic          succ;
   logic          step;
   logic          inc;
   logic          dec;
   logic          bp_en;
   logic [31:0]   bp_addr;
   logic [31:0]   pc;
   logic          cpu_en;
   logic [AW-1:0] m_rf_addr;
   logic          halted;
   logic          bp_hit_o;
   logic [31:0]   en_cnt;

   modport master (
      output succ, step, inc, dec, bp_en, bp_addr, pc,
      input  cpu_en, m_rf_addr, halted, bp_hit_o, en_cnt
   );

   modport slave (
      input  succ, step, inc, dec, bp_en, bp_addr, pc,
      output cpu_en, m_rf_addr, halted, bp_hit_o, en_cnt
   );
endinterface : dbu_run_ctrl_if
`default_nettype wire

// File: rtl/dbu_run_ctrl_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module   : btn_cond
//  Purpose  : Conditions one raw push-button: 2-flop synchronizer, debounce
//             counter and a one-cycle pulse on each accepted 0->1 change.
//  Ports    : clk      system clock
//             rst      asynchronous active-low reset
//             i_btn    raw button level
//             o_pulse  one-cycle pulse per accepted press
//  Revision : 1.0  initial release
// ============================================================================
module btn_cond
   import dbu_run_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = c_DB_CYCLES_DEFAULT
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_btn,
   output logic      o_pulse
);

   localparam int            c_CW      = $clog2(DB_CYCLES + 1);
   localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DB_CYCLES - 1);

   logic [1:0]      r_sync;
   logic [c_CW-1:0] r_cnt;
   logic            r_level;
   logic            r_pulse;

   // r_cnt counts consecutive cycles in which the synchronized input
   // disagrees with the debounced level; any agreement restarts it, so the
   // level only follows after DB_CYCLES uninterrupted cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync  <= 2'b00;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_pulse <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_pulse <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule : btn_cond
`default_nettype wire

// File: rtl/dbu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dbu_run_ctrl
//  Purpose  : Debug-unit run-control sequencer. Produces a single-clock CPU
//             enable (continuous run / single step / one PC breakpoint) and a
//             wrapping debug view address driven by inc/dec buttons.
//  Ports    : clk   system clock
//             rst   asynchronous active-low reset
//             bus   dbu_run_ctrl_if.slave: succ/step/inc/dec, bp_en, bp_addr,
//                   pc in; cpu_en, m_rf_addr, halted, bp_hit_o, en_cnt out
//  Revision : 1.0  initial release
// ============================================================================
module dbu_run_ctrl
   import dbu_run_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = c_DB_CYCLES_DEFAULT,
   parameter int AW        = 9
) (
   input  wire logic       clk,
   input  wire logic       rst,
   dbu_run_ctrl_if.slave   bus
);

   logic          w_step_p;
   logic          w_inc_p;
   logic          w_dec_p;
   logic [1:0]    r_succ_sync;
   logic          w_succ_s;
   logic          w_bp_hit;
   run_state_e    r_state;
   run_state_e    w_next;
   logic          w_cpu_en;
   logic          w_halted;
   logic          w_in_break;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_en_cnt;

   // ------------------------------------------------------------------
   // Button conditioning
   // ------------------------------------------------------------------
   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_step (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (bus.step),
      .o_pulse (w_step_p)
   );

   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_inc (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (bus.inc),
      .o_pulse (w_inc_p)
   );

   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_dec (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (bus.dec),
      .o_pulse (w_dec_p)
   );

   // The run switch is a level, so it is only synchronized, not debounced.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_succ_sync <= 2'b00;
      end else begin
         r_succ_sync <= {r_succ_sync[0], bus.succ};
      end
   end

   assign w_succ_s = r_succ_sync[1];
   assign w_bp_hit = bus.bp_en & (bus.pc == bus.bp_addr);

   // ------------------------------------------------------------------
   // Run-control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_HALT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_HALT: begin
            if (w_step_p) begin
               w_next = ST_STEP;
            end else if (w_succ_s) begin
               w_next = ST_RUN;
            end
         end
         // A step pulse arriving here is intentionally ignored.
         ST_STEP: begin
            w_next = ST_HALT;
         end
         ST_RUN: begin
            if (!w_succ_s) begin
               w_next = ST_HALT;
            end else if (w_bp_hit) begin
               w_next = ST_BREAK;
            end
         end
         ST_BREAK: begin
            // Stepping out of BREAK executes the breakpoint instruction;
            // the following HALT then resumes RUN if the switch is still on.
            if (!w_succ_s) begin
               w_next = ST_HALT;
            end else if (w_step_p) begin
               w_next = ST_STEP;
            end
         end
         default: begin
            w_next = ST_HALT;
         end
      endcase
   end

   // In RUN the enable is withheld in the very cycle the breakpoint matches
   // or the switch drops, so the instruction at bp_addr is never issued.
   always_comb begin
      w_cpu_en   = 1'b0;
      w_halted   = 1'b0;
      w_in_break = 1'b0;
      unique case (r_state)
         ST_HALT:  w_halted   = 1'b1;
         ST_STEP:  w_cpu_en   = 1'b1;
         ST_RUN:   w_cpu_en   = ~w_bp_hit & w_succ_s;
         ST_BREAK: begin
            w_halted   = 1'b1;
            w_in_break = 1'b1;
         end
         default:  w_halted   = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Debug view address and enable counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr <= '0;
      end else begin
         unique case ({w_inc_p, w_dec_p})
            2'b10:   r_addr <= r_addr + 1'b1;
            2'b01:   r_addr <= r_addr - 1'b1;
            default: r_addr <= r_addr;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_en_cnt <= 32'd0;
      end else if (w_cpu_en) begin
         r_en_cnt <= r_en_cnt + 32'd1;
      end
   end

   assign bus.cpu_en    = w_cpu_en;
   assign bus.halted    = w_halted;
   assign bus.bp_hit_o  = w_in_break;
   assign bus.m_rf_addr = r_addr;
   assign bus.en_cnt    = r_en_cnt;

endmodule : dbu_run_ctrl
`default_nettype wire

// File: tb/tb_dbu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbu_run_ctrl
//  Purpose  : Self-checking bench for dbu_run_ctrl with a PC model and
//             scoreboards for CPU enables and view-address updates.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dbu_run_ctrl;

   localparam int DB = 4;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   int            errors = 0;
   int            checks = 0;
   logic [31:0]   exp_pc_q[$];
   logic [AW-1:0] exp_addr_q[$];
   logic [AW-1:0] prev_addr = '0;
   logic [31:0]   e_pc;
   logic [AW-1:0] e_addr;

   dbu_run_ctrl_if #(.AW(AW)) bus();

   dbu_run_ctrl #(.DB_CYCLES(DB), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // CPU PC model: one 4-byte instruction per enabled cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) bus.pc <= 32'd0;
      else if (bus.cpu_en) bus.pc <= bus.pc + 32'd4;
   end

   // Scoreboard consumers: every enable must match the next expected PC and
   // every address change the next expected address.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.cpu_en === 1'b1) begin
            checks++;
            if (exp_pc_q.size() == 0) begin
               errors++;
               $display("FAIL enable_unexpected: cpu_en=1 at pc=%h, required no enable", bus.pc);
            end else begin
               e_pc = exp_pc_q.pop_front();
               if (bus.pc !== e_pc) begin
                  errors++;
                  $display("FAIL enable_pc: pc=%h, required %h", bus.pc, e_pc);
               end
            end
         end
         if (bus.m_rf_addr !== prev_addr) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
               errors++;
               $display("FAIL addr_unexpected: m_rf_addr=%h, required %h", bus.m_rf_addr, prev_addr);
            end else begin
               e_addr = exp_addr_q.pop_front();
               if (bus.m_rf_addr !== e_addr) begin
                  errors++;
                  $display("FAIL addr_update: m_rf_addr=%h, required %h", bus.m_rf_addr, e_addr);
               end
            end
         end
      end
      prev_addr = bus.m_rf_addr;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input bit s, input bit i, input bit d, input int hold);
      bus.step = s;
      bus.inc  = i;
      bus.dec  = d;
      idle(hold);
      bus.step = 1'b0;
      bus.inc  = 1'b0;
      bus.dec  = 1'b0;
      idle(12);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(2);
   endtask

   task automatic test_reset();
      bus.succ = 1'b0; bus.step = 1'b0; bus.inc = 1'b0; bus.dec = 1'b0;
      bus.bp_en = 1'b0; bus.bp_addr = 32'd0;
      rst = 1'b0;
      idle(3);
      checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b, required 0", bus.cpu_en); end
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b, required 1", bus.halted); end
      checks++; if (bus.bp_hit_o !== 1'b0) begin errors++; $display("FAIL reset_bp_hit: got %b, required 0", bus.bp_hit_o); end
      checks++; if (bus.m_rf_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h, required 0", bus.m_rf_addr); end
      checks++; if (bus.en_cnt !== 32'd0) begin errors++; $display("FAIL reset_en_cnt: got %0d, required 0", bus.en_cnt); end
      rst = 1'b1;
      idle(2);
   endtask

   task automatic test_step();
      exp_pc_q.push_back(32'h0);
      press(1'b1, 1'b0, 1'b0, 10);
      checks++; if (bus.en_cnt !== 32'd1) begin errors++; $display("FAIL step_en_cnt: got %0d, required 1", bus.en_cnt); end
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL step_halted: got %b, required 1", bus.halted); end
      checks++; if (exp_pc_q.size() != 0) begin errors++; $display("FAIL step_pending: %0d enables missing, required 0", exp_pc_q.size()); end
      checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL step_pc: got %h, required 4", bus.pc); end
   endtask

   task automatic test_debounce();
      exp_addr_q.push_back(9'd1);
      for (int k = 0; k < 10; k++) begin
         bus.inc = k[0];
         idle(2);
      end
      idle(10);
      bus.inc = 1'b0;
      idle(12);
      checks++; if (bus.m_rf_addr !== 9'd1) begin errors++; $display("FAIL debounce_addr: got %h, required 001", bus.m_rf_addr); end
      checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL debounce_pending: %0d updates missing, required 0", exp_addr_q.size()); end
   endtask

   task automatic test_wrap();
      exp_addr_q.push_back(9'h000);
      press(1'b0, 1'b0, 1'b1, 10);
      checks++; if (bus.m_rf_addr !== 9'h000) begin errors++; $display("FAIL wrap_dec1: got %h, required 000", bus.m_rf_addr); end
      exp_addr_q.push_back(9'h1FF);
      press(1'b0, 1'b0, 1'b1, 10);
      checks++; if (bus.m_rf_addr !== 9'h1FF) begin errors++; $display("FAIL wrap_under: got %h, required 1ff", bus.m_rf_addr); end
      exp_addr_q.push_back(9'h000);
      press(1'b0, 1'b1, 1'b0, 10);
      checks++; if (bus.m_rf_addr !== 9'h000) begin errors++; $display("FAIL wrap_over: got %h, required 000", bus.m_rf_addr); end
      press(1'b0, 1'b1, 1'b1, 10);
      checks++; if (bus.m_rf_addr !== 9'h000) begin errors++; $display("FAIL wrap_both: got %h, required 000", bus.m_rf_addr); end
   endtask

   task automatic test_breakpoint();
      int n;
      apply_reset();
      bus.bp_en = 1'b1;
      bus.bp_addr = 32'h0C;
      exp_pc_q.push_back(32'h0);
      exp_pc_q.push_back(32'h4);
      exp_pc_q.push_back(32'h8);
      bus.succ = 1'b1;
      n = 0;
      while (bus.bp_hit_o !== 1'b1 && n < 40) begin
         idle(1);
         n++;
      end
      checks++; if (bus.bp_hit_o !== 1'b1) begin errors++; $display("FAIL bp_reach: bp_hit_o=%b after %0d cycles, required 1", bus.bp_hit_o, n); end
      idle(5);
      checks++; if (bus.en_cnt !== 32'd3) begin errors++; $display("FAIL bp_en_cnt: got %0d, required 3", bus.en_cnt); end
      checks++; if (bus.pc !== 32'h0C) begin errors++; $display("FAIL bp_pc: got %h, required 0c", bus.pc); end
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %b, required 1", bus.halted); end
      // Move the breakpoint ahead so the resumed run stops again at 0x20.
      bus.bp_addr = 32'h20;
      exp_pc_q.push_back(32'h0C);
      exp_pc_q.push_back(32'h10);
      exp_pc_q.push_back(32'h14);
      exp_pc_q.push_back(32'h18);
      exp_pc_q.push_back(32'h1C);
      press(1'b1, 1'b0, 1'b0, 10);
      checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL bp_resume_pc: got %h, required 20", bus.pc); end
      checks++; if (bus.en_cnt !== 32'd8) begin errors++; $display("FAIL bp_resume_cnt: got %0d, required 8", bus.en_cnt); end
      checks++; if (bus.bp_hit_o !== 1'b1) begin errors++; $display("FAIL bp_rebreak: got %b, required 1", bus.bp_hit_o); end
      bus.succ = 1'b0;
      idle(5);
      checks++; if (bus.halted !== 1'b1 || bus.bp_hit_o !== 1'b0) begin errors++; $display("FAIL bp_stop: halted=%b bp_hit_o=%b, required 1/0", bus.halted, bus.bp_hit_o); end
      bus.bp_en = 1'b0;
   endtask

   task automatic test_start_on_bp();
      apply_reset();
      bus.bp_en = 1'b1;
      bus.bp_addr = 32'h0;
      bus.succ = 1'b1;
      idle(10);
      checks++; if (bus.bp_hit_o !== 1'b1) begin errors++; $display("FAIL startbp_break: got %b, required 1", bus.bp_hit_o); end
      checks++; if (bus.en_cnt !== 32'd0) begin errors++; $display("FAIL startbp_en_cnt: got %0d, required 0", bus.en_cnt); end
      bus.succ = 1'b0;
      bus.bp_en = 1'b0;
      idle(5);
   endtask

   task automatic test_async_reset();
      int n;
      apply_reset();
      exp_addr_q.push_back(9'd1);
      press(1'b0, 1'b1, 1'b0, 10);
      checks++; if (bus.m_rf_addr !== 9'd1) begin errors++; $display("FAIL arst_addr_pre: got %h, required 001", bus.m_rf_addr); end
      for (int k = 0; k < 40; k++) exp_pc_q.push_back(32'(4 * k));
      bus.succ = 1'b1;
      n = 0;
      while (bus.en_cnt < 32'd10 && n < 40) begin
         idle(1);
         n++;
      end
      checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL arst_running: cpu_en=%b en_cnt=%0d, required running", bus.cpu_en, bus.en_cnt); end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL arst_cpu_en: got %b, required 0", bus.cpu_en); end
      checks++; if (bus.en_cnt !== 32'd0) begin errors++; $display("FAIL arst_en_cnt: got %0d, required 0", bus.en_cnt); end
      checks++; if (bus.m_rf_addr !== '0) begin errors++; $display("FAIL arst_addr: got %h, required 000", bus.m_rf_addr); end
      exp_pc_q.delete();
      bus.succ = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(5);
      checks++; if (bus.halted !== 1'b1 || bus.cpu_en !== 1'b0) begin errors++; $display("FAIL arst_release: halted=%b cpu_en=%b, required 1/0", bus.halted, bus.cpu_en); end
   endtask

   initial begin
      test_reset();
      test_step();
      test_debounce();
      test_wrap();
      test_breakpoint();
      test_start_on_bp();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dbu_run_ctrl
`default_nettype wire

// File: doc/dbu_run_ctrl.md
# dbu_run_ctrl

Run-control sequencer for the debug unit. It turns the raw `succ` switch and the `step`, `inc` and `dec` buttons into a gated CPU clock-enable and a wrapping memory/register-file view address. It supports continuous run, single step and one PC breakpoint. It sits between the board I/O and the `cpu` instance and replaces ad-hoc clock muxing with a single-clock enable scheme.

## Interface
- `DB_CYCLES`, default 50000: cycles a button must be stable before a press is accepted (≥2).
- `AW`, default 9: width of `m_rf_addr`.
- `clk` input 1: system clock, the only clock.
- `rst` input 1: reset, asynchronous, active-low.
- `succ` input 1: raw run switch; 1 = continuous run.
- `step` input 1: raw single-step button.
- `inc` input 1: raw address-increment button.
- `dec` input 1: raw address-decrement button.
- `bp_en` input 1: breakpoint enable, synchronous to `clk`.
- `bp_addr` input 32: breakpoint PC.
- `pc` input 32: current CPU PC.
- `cpu_en` output 1: CPU clock enable, one instruction per high cycle.
- `m_rf_addr` output AW: debug view address.
- `halted` output 1: 1 in HALT or BREAK.
- `bp_hit_o` output 1: 1 while in BREAK.
- `en_cnt` output 32: count of cycles with `cpu_en` high.

## Operation
- Button conditioning: each of `step`/`inc`/`dec` passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level changes only after the synchronized input has been stable for DB_CYCLES consecutive cycles.
  - A one-cycle `*_p` pulse is produced on each debounced 0→1 transition.
- `succ` uses a 2-flop synchronizer only; the result is `succ_s`.
- `bp_hit` = `bp_en & (pc == bp_addr)`, combinational.
- FSM states: HALT, RUN, STEP, BREAK. Reset state is HALT.
  - HALT: if `step_p` → STEP; else if `succ_s` → RUN.
  - STEP: → HALT unconditionally. `step_p` arriving while in STEP is dropped.
  - RUN:
    - if `!succ_s` → HALT;
    - else if `bp_hit` → BREAK;
    - else stay.
  - BREAK:
    - if `!succ_s` → HALT;
    - else if `step_p` → STEP, which steps past the breakpoint;
    - else stay.
  - After a BREAK→STEP→HALT sequence with `succ_s` still high, the next cycle goes to RUN.
- `cpu_en` = (state==STEP) | (state==RUN & ~bp_hit & succ_s), combinational from state.
  - The instruction at `bp_addr` is never executed while in RUN.
  - Entering RUN with `pc==bp_addr` goes straight to BREAK with zero enables.
- `m_rf_addr`:
  - +1 on `inc_p`, −1 on `dec_p`, modulo 2^AW (0x1FF+1 → 0, 0−1 → 0x1FF).
  - `inc_p` and `dec_p` in the same cycle → unchanged.
  - The address is independent of FSM state.
- `en_cnt`: +1 every cycle `cpu_en`=1, wraps at 2^32.

## Timing
- Reset values: state HALT, `cpu_en` 0, `halted` 1, `bp_hit_o` 0, `m_rf_addr` 0, `en_cnt` 0, all debounce counters and synchronizers 0.
- Reset asserted mid-RUN forces `cpu_en` 0 immediately (asynchronous).
- Press latency: raw edge → `*_p` after 2 sync cycles + DB_CYCLES.
- `step_p` in HALT at cycle t: state STEP at t+1, `cpu_en`=1 during t+1 only, HALT at t+2.
- `succ_s` rising in HALT at cycle t: RUN at t+1; `cpu_en` high from t+1 while `bp_hit`=0.
- `succ_s` falling in RUN at cycle t: `cpu_en`=0 in cycle t, HALT at t+1.
- `bp_hit` in RUN at cycle t: `cpu_en`=0 in cycle t, BREAK at t+1.
- `m_rf_addr` and `en_cnt` update on the clock edge after the pulse/enable cycle.
- `halted` and `bp_hit_o` are decoded from registered state, so they are glitch-free.

## Structure
- Shared debug package holds:
  - the state enum (HALT=2'd0, RUN=2'd1, STEP=2'd2, BREAK=2'd3);
  - the default DB_CYCLES constant.
- Sub-module `btn_cond`: synchronizer + debounce counter + rising-edge pulse, parameterized by DB_CYCLES. Instantiated three times.
- `succ` synchronizer, FSM, address counter and `en_cnt` live in the top level.

## Test plan
All scenarios use DB_CYCLES=4.
- Reset + step: release `rst`, press `step` for 10 cycles → exactly one `cpu_en` cycle, `en_cnt`=1, `halted` back to 1.
- Debounce: toggle `inc` every 2 cycles for 20 cycles, then hold for 10 cycles → `m_rf_addr` 0→1 only once.
- Address wrap: 1 `dec` press from 0 → 0x1FF. Then 1 `inc` press → 0x000. Simultaneous `inc_p`/`dec_p` → no change.
- Breakpoint run: `bp_en`=1, `bp_addr`=0x0C, PC model advances by 4 per enable from 0, `succ`=1 → 3 enables, `pc` holds at 0x0C, `bp_hit_o`=1, `en_cnt`=3. Then `step` → `pc`=0x10, and the FSM returns to RUN until `succ` is dropped.
- Start on breakpoint: `pc`=`bp_addr`=0, `succ`=1 → BREAK with 0 enables.
- Async reset mid-RUN: assert `rst`=0 between clock edges → `cpu_en` 0 immediately, `en_cnt` and `m_rf_addr` 0, state HALT after release.
